// File: rtl/regfile_reader.sv
// Purpose : sweeps register file addresses FIRST_REG..LAST_REG over one read port,
//           streams each word out on valid/ready and accumulates a 32-bit checksum.
// Latency : start -> first out_valid 2 cycles; 2 cycles per word with out_ready high.
// Backpressure: out_ready low holds the presented word stable; the sweep stalls in HOLD.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a sweep (honoured only in IDLE)
//   rd_addr / rd_data       register file read port (address registered, data combinational)
//   out_valid/out_ready     output stream handshake
//   out_addr/out_data/out_last  current word, its address, last-word flag
//   busy, done, state       status: READ/HOLD decode, end-of-sweep pulse, debug state
//   sum, sum_valid          running checksum and its final-value flag
module regfile_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        sum_valid,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

    state_t      state_q, state_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_addr_q, out_addr_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] sum_q, sum_d;
    logic        sum_valid_q, sum_valid_d;

    logic        accept;

    assign accept = out_valid_q & out_ready;

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= 5'd0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 5'd0;
            out_data_q  <= 32'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= 32'd0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_READ;
            S_READ: state_d = S_HOLD;
            S_HOLD: if (accept) state_d = out_last_q ? S_DONE : S_READ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic. busy and done are registered decodes of the
    // next state so they line up exactly with the cycles spent in that state.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        busy_d      = (state_d == S_READ) || (state_d == S_HOLD);
        done_d      = (state_d == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d   = FIRST_ADDR;
                    sum_d       = 32'd0;
                    sum_valid_d = 1'b0;
                end
            end
            S_READ: begin
                // rd_addr has been stable for a whole cycle; sample the read here.
                out_data_d  = rd_data;
                out_addr_d  = rd_addr_q;
                out_last_d  = (rd_addr_q == LAST_ADDR);
                out_valid_d = 1'b1;
            end
            S_HOLD: begin
                if (accept) begin
                    sum_d       = sum_q + out_data_q;
                    out_valid_d = 1'b0;
                    // Only advance when not at the end, so rd_addr never passes LAST_REG.
                    if (!out_last_q) rd_addr_d = rd_addr_q + 5'd1;
                end
            end
            S_DONE: begin
                sum_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign state     = state_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: three instances (full range, single register 5, range 1..3),
// each with its own register file model, checked against a queue of expected beats.
module tb_regfile_reader;

    typedef struct packed {
        logic        last;
        logic [4:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        start     [3];
    logic [4:0]  rd_addr   [3];
    logic [31:0] rd_data   [3];
    logic        out_valid [3];
    logic [4:0]  out_addr  [3];
    logic [31:0] out_data  [3];
    logic        out_last  [3];
    logic        busy      [3];
    logic        done      [3];
    logic [31:0] sum       [3];
    logic        sum_valid [3];
    logic [1:0]  state     [3];
    logic [31:0] regs      [3][32];

    beat_t q[$];
    int    nchk  = 0;
    int    nfail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rd_data[g] = regs[g][rd_addr[g]];
        regfile_reader #(
            .FIRST_REG(g == 0 ? 0  : (g == 1 ? 5 : 1)),
            .LAST_REG (g == 0 ? 31 : (g == 1 ? 5 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .rd_addr  (rd_addr[g]),
            .rd_data  (rd_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(ready),
            .out_addr (out_addr[g]),
            .out_data (out_data[g]),
            .out_last (out_last[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .sum      (sum[g]),
            .sum_valid(sum_valid[g]),
            .state    (state[g])
        );
    end

    function automatic int fr(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 5 : 1);
    endfunction

    function automatic int lr(input int g);
        return (g == 0) ? 31 : ((g == 1) ? 5 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input int g, input string tag);
        chk($sformatf("%s[%0d].state", tag, g), 32'(state[g]), 32'd0);
        chk($sformatf("%s[%0d].rd_addr", tag, g), 32'(rd_addr[g]), 32'd0);
        chk($sformatf("%s[%0d].out_valid", tag, g), 32'(out_valid[g]), 32'd0);
        chk($sformatf("%s[%0d].out_addr", tag, g), 32'(out_addr[g]), 32'd0);
        chk($sformatf("%s[%0d].out_data", tag, g), out_data[g], 32'd0);
        chk($sformatf("%s[%0d].out_last", tag, g), 32'(out_last[g]), 32'd0);
        chk($sformatf("%s[%0d].busy", tag, g), 32'(busy[g]), 32'd0);
        chk($sformatf("%s[%0d].done", tag, g), 32'(done[g]), 32'd0);
        chk($sformatf("%s[%0d].sum", tag, g), sum[g], 32'd0);
        chk($sformatf("%s[%0d].sum_valid", tag, g), 32'(sum_valid[g]), 32'd0);
    endtask

    // One complete sweep on instance g. bp selects the 0,0,1 ready pattern;
    // restart_at >= 0 pulses start again while that many beats have gone;
    // exp_done_n > 0 also checks the cycle (edges after start) of the done pulse.
    task automatic run(input string tag, input int g, input bit bp, input int restart_at,
                       input logic [31:0] exp_sum, input int exp_done_n);
        int          n, beats, dones, nexp, first, last;
        bit          restarted, fin;
        logic        pv, pr, pl;
        logic [4:0]  pa;
        logic [31:0] pd;
        beat_t       e;
        first = fr(g);
        last  = lr(g);
        q.delete();
        for (int a = first; a <= last; a++)
            q.push_back({1'(a == last), 5'(a), regs[g][a]});
        nexp = last - first + 1;
        n = 0; beats = 0; dones = 0; restarted = 1'b0; fin = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = 5'd0; pd = 32'd0;

        @(negedge clk);
        start[g] = 1'b1;
        ready    = bp ? 1'b0 : 1'b1;
        while (!fin && n < 400) begin
            @(negedge clk);
            n++;
            start[g] = 1'b0;
            if (restart_at >= 0 && !restarted && beats == restart_at && out_valid[g]) begin
                start[g]  = 1'b1;
                restarted = 1'b1;
            end
            ready = bp ? (n % 3 == 2) : 1'b1;
            if (pv && !pr) begin
                chk({tag, ".hold_valid"}, 32'(out_valid[g]), 32'd1);
                chk({tag, ".hold_data"}, out_data[g], pd);
                chk({tag, ".hold_addr"}, 32'(out_addr[g]), 32'(pa));
                chk({tag, ".hold_last"}, 32'(out_last[g]), 32'(pl));
            end
            if (out_valid[g] && ready) begin
                if (q.size() == 0) begin
                    chk({tag, ".extra_beat"}, 32'(beats), 32'(nexp - 1));
                end else begin
                    e = q.pop_front();
                    chk({tag, ".beat_addr"}, 32'(out_addr[g]), 32'(e.addr));
                    chk({tag, ".beat_data"}, out_data[g], e.data);
                    chk({tag, ".beat_last"}, 32'(out_last[g]), 32'(e.last));
                end
                beats++;
            end
            if (done[g]) begin
                dones++;
                if (exp_done_n > 0) chk({tag, ".done_cycle"}, 32'(n), 32'(exp_done_n));
                chk({tag, ".busy_in_done"}, 32'(busy[g]), 32'd0);
                chk({tag, ".state_in_done"}, 32'(state[g]), 32'd3);
            end
            if (sum_valid[g] && dones > 0) fin = 1'b1;
            pv = out_valid[g]; pr = ready; pd = out_data[g]; pa = out_addr[g]; pl = out_last[g];
        end
        ready = 1'b1;
        chk({tag, ".finished_in_budget"}, 32'(fin), 32'd1);
        chk({tag, ".beat_count"}, 32'(beats), 32'(nexp));
        chk({tag, ".done_count"}, 32'(dones), 32'd1);
        chk({tag, ".queue_empty"}, 32'(q.size()), 32'd0);
        chk({tag, ".sum"}, sum[g], exp_sum);
        @(negedge clk);
        chk({tag, ".done_after"}, 32'(done[g]), 32'd0);
        chk({tag, ".sum_valid_hold"}, 32'(sum_valid[g]), 32'd1);
        chk({tag, ".sum_hold"}, sum[g], exp_sum);
        chk({tag, ".idle_after"}, 32'(state[g]), 32'd0);
    endtask

    task automatic reset_mid_sweep();
        int n;
        n = 0;
        @(negedge clk);
        start[0] = 1'b1;
        ready    = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (!(out_valid[0] && out_addr[0] == 5'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid.reached_beat5", 32'(out_valid[0] && out_addr[0] == 5'd5), 32'd1);
        chk("rst_mid.sum_before", sum[0], 32'd30);
        chk("rst_mid.busy_before", 32'(busy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0, "rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals(0, "rst_mid_after");
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0;
            for (int i = 0; i < 32; i++) regs[g][i] = $urandom;
        end
        for (int i = 0; i < 32; i++) regs[0][i] = 32'(3 * i);
        regs[1][5] = 32'hDEADBEEF;
        regs[2][1] = 32'hFFFFFFFF;
        regs[2][2] = 32'h00000002;
        regs[2][3] = 32'h80000000;

        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) chk_reset_vals(g, "reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run("full", 0, 1'b0, -1, 32'd1488, 65);
        run("backpressure", 0, 1'b1, -1, 32'd1488, 0);
        run("start_busy", 0, 1'b0, 10, 32'd1488, 65);
        reset_mid_sweep();
        run("after_reset", 0, 1'b0, -1, 32'd1488, 65);
        run("single", 1, 1'b0, -1, 32'hDEADBEEF, 3);
        run("wrap", 2, 1'b0, -1, 32'h80000001, 7);
        run("wrap_bp", 2, 1'b1, -1, 32'h80000001, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sequential read-out engine for the register file. On a `start` pulse it walks a register address range over one read port, presents each word on a valid/ready output stream, and accumulates a 32-bit checksum. It is the consumer counterpart of the compute sequencer that writes the register file through `r3_wr`. It shares the regfile read port (`r1_addr`/`r1_dout` side) with that sequencer once computation has finished, and feeds a debug/dump path.

## Interface
Parameters:
- `FIRST_REG`, default 0: first register address read; legal range 0..31.
- `LAST_REG`, default 31: last register address read; legal range `FIRST_REG`..31.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a sweep; sampled only in IDLE.
- `rd_addr`, out, 5: register file read address (registered).
- `rd_data`, in, 32: register file read data; combinational function of `rd_addr`.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: downstream accepts the word.
- `out_addr`, out, 5: register address of the current word.
- `out_data`, out, 32: register contents.
- `out_last`, out, 1: current word is from `LAST_REG`.
- `busy`, out, 1: high in READ or HOLD.
- `done`, out, 1: one-cycle pulse at sweep end.
- `sum`, out, 32: running checksum.
- `sum_valid`, out, 1: `sum` is final.
- `state`, out, 2: FSM state for debug. IDLE=0, READ=1, HOLD=2, DONE=3.

## Operation
- **Reset values.** `state`=IDLE, `rd_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `sum`=0, `sum_valid`=0.
- **IDLE**
  - If `start`=1: `rd_addr`<=`FIRST_REG`, `sum`<=0, `sum_valid`<=0, go to READ.
  - Otherwise stay in IDLE.
- **READ.** Capture the word and go to HOLD:
  - `out_data`<=`rd_data`, `out_addr`<=`rd_addr`
  - `out_last`<=(`rd_addr`==`LAST_REG`), `out_valid`<=1
- **HOLD**
  - While `out_ready`=0: hold `out_valid`, `out_data`, `out_addr` and `out_last` stable.
  - On `out_valid`&&`out_ready`: `sum`<=`sum`+`out_data` (mod 2^32, carry discarded).
    - If `out_last`: `out_valid`<=0, go to DONE.
    - Else: `rd_addr`<=`rd_addr`+1, `out_valid`<=0, go to READ.
- **DONE.** `done`=1 for exactly this cycle, `sum_valid`<=1, go to IDLE.
  - `sum` and `sum_valid` hold until the next accepted `start`.
- `start` is ignored in READ, HOLD and DONE. It is not queued.
- `out_valid` never drops without a handshake, except on reset.
- `rd_addr` never exceeds `LAST_REG` and never wraps past 31.
- **Reset mid-sweep.** All outputs return to reset values immediately. There is no partial-sum retention, and no `done` is emitted.

## Timing
- `busy` is a registered decode of `state`: high in the cycles where `state` is READ or HOLD.
- Start to first `out_valid`: 2 cycles.
  - Edge 1 samples `start` and enters READ.
  - Edge 2 captures the word and asserts `out_valid`.
- Per word, with `out_ready` tied high: 2 cycles (READ, HOLD). A sweep of N words takes 2N cycles.
- Final handshake to `done`: `done` is high the cycle after the last accepted beat. `sum_valid` rises one cycle later and stays high.
- `rd_data` is sampled at the end of READ. `rd_addr` has been stable since the previous edge, so the regfile's combinational read has a full cycle.
- Register 0 returns whatever the regfile drives (0 in the current regfile). No special-casing.

## Test plan
- **Full sweep, no backpressure.** Preload reg i = 3*i, `out_ready`=1, pulse `start`.
  - Required: 32 beats, `out_addr` 0..31, `out_data` 3*i, `out_last` only on addr 31.
  - Required: `done` pulse after cycle 64 of the sweep; `sum`=1488 with `sum_valid`=1.
- **Backpressure.** Same preload, `out_ready` toggled 0,0,1 repeating.
  - Required: each word held stable while `out_ready`=0, no beat lost or duplicated, final `sum`=1488.
- **Start while busy.** Pulse `start` again at beat 10.
  - Required: ignored; a single sweep, a single `done`, `sum`=1488.
- **Reset mid-sweep.** Assert `rst_n`=0 asynchronously between edges during beat 5.
  - Required: `out_valid`, `busy`, `sum` and `state` go to 0 without waiting for a clock edge.
  - Required: a new `start` afterwards produces a full correct sweep.
- **Single-register range.** `FIRST_REG`=`LAST_REG`=5, reg5=0xDEADBEEF.
  - Required: one beat with `out_addr`=5 and `out_last`=1; `sum`=0xDEADBEEF.
- **Checksum wrap.** `FIRST_REG`=1, `LAST_REG`=3, regs = 0xFFFFFFFF, 0x00000002, 0x80000000.
  - Required: `sum`=0x80000001, with carries discarded.
